sim_mem_nport: RTL and testbench
================================

# sim_mem_nport

Parametrised multi-channel simulation memory for the CPU testbench, replacing the fixed single-port instruction/data memory models. It provides NPORT independent request/response channels into one shared word array, a configurable pipelined response latency, byte strobes, out-of-range error reporting, and a hardware program-exit register. The CPU instruction fetch and data ports attach to separate channels; the bench watches `exit_v` instead of probing CPU internals.

## Interface

Parameters:
- `XLEN`, 32: word width in bits; strobe width is XLEN/8.
- `NPORT`, 2: number of channels, 1..4.
- `BASE_ADR`, 32'h10000: byte address of word 0.
- `DEPTH`, 8192: number of words in `mem`.
- `LATENCY`, 1: cycles from accept to response, 1..8.
- `EXIT_ADR`, 32'h0: write-only program-exit address.
- `STALL_SEED`, 16'hACE1: LFSR seed, used only with stall injection.

Ports:
- `clk`  in  1  clock.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `r_v`  in  [NPORT]  read request.
- `w_v`  in  [NPORT]  write request; if both are set, the request is a write.
- `adr`  in  [NPORT][XLEN]  byte address; bits [1:0] are ignored.
- `data`  in  [NPORT][XLEN]  write data.
- `strobe`  in  [NPORT][XLEN/8]  byte enables for writes.
- `ready`  out  [NPORT]  channel can accept a request this cycle.
- `resp`  out  [NPORT][XLEN]  response data.
- `resp_valid`  out  [NPORT]  one-cycle response pulse.
- `resp_err`  out  [NPORT]  response is for an out-of-range address; valid with `resp_valid`.
- `exit_v`  out  1  sticky exit flag.
- `exit_code`  out  XLEN  data from the exit write.

## Operation

- **Storage:** `mem[DEPTH]` holds XLEN-bit words. It is not reset and is preloaded hierarchically by the bench.
- **Address decode:** index = (adr - BASE_ADR) >> 2. The address is in range when BASE_ADR <= adr < BASE_ADR + 4*DEPTH.
- **Accept:** a request is accepted on a rising edge when (r_v|w_v) && ready for that channel. Each channel accepts one request per cycle, fully pipelined.
- **Read:**
  - The data is sampled at the accept edge.
  - In range: resp = mem[index], resp_err = 0.
  - Out of range: resp = 0, resp_err = 1.
- **Write, in range:**
  - Bytes with strobe set are updated at the accept edge.
  - The response carries the merged new word, resp_err = 0.
- **Write, out of range (not EXIT_ADR):**
  - Memory is unchanged.
  - The response has resp = 0, resp_err = 1.
- **Exit write:** a write to exactly EXIT_ADR does the following:
  - Sets exit_v = 1 and exit_code = data, ignoring strobe.
  - Leaves memory unchanged.
  - Responds with resp = data, resp_err = 0.
  - exit_v stays high until reset. A later exit write overwrites exit_code.
  - Reads of EXIT_ADR are out of range.
- **Same-cycle conflicts:**
  - A read and a write to the same word on different channels: the read returns the old word.
  - Two writes to the same word: per byte, the highest-index channel with that strobe bit set wins.
  - Simultaneous exit writes: the highest-index channel's data wins.
- **Ordering:** responses on each channel return in accept order. There is no ordering between channels.

## Timing

- **Latency:** a request accepted at edge t produces resp_valid high for exactly one cycle, registered, starting at edge t+LATENCY. With LATENCY=1 the response is visible the cycle after accept.
- **Pipeline:** a per-channel shift pipeline of depth LATENCY carries {valid, err, data}. resp and resp_err hold their last value while resp_valid is low.
- **Ready, stall injection disabled:** ready = 1 from the first edge after rst_n deasserts.
- **Exit flag timing:** exit_v and exit_code update at the accept edge of the exit write, ahead of its response.
- **Reset values:** ready = 0, resp_valid = 0, resp = 0, resp_err = 0, exit_v = 0, exit_code = 0.
- **Reset mid-operation:**
  - Asserting rst_n flushes all pipelines immediately; no response for an in-flight request ever appears.
  - Memory contents are preserved.

## Configuration

- **Macro:** `SIM_MEM_STALL_INJECT_EN`.
- **Defined:**
  - Each channel has a 16-bit Fibonacci LFSR, polynomial x^16+x^14+x^13+x^11+1, seeded with STALL_SEED ^ channel index at reset.
  - The LFSR advances every cycle after reset.
  - ready = 0 when lfsr[3:0] == 0, otherwise 1; this deasserts ready about one cycle in 16.
  - Requests presented while ready = 0 are not accepted, and the requester must hold them.
- **Not defined:** there is no LFSR logic and ready behaves as stated in Timing.

## Test plan

- **Read latency:** preload mem[0]=32'hDEADBEEF, LATENCY=3, read 32'h10000 on ch0 at edge t -> resp_valid at t+3 only, resp=32'hDEADBEEF, resp_err=0.
- **Strobed write:** mem[1]=32'h11223344; ch1 writes 32'hAABBCCDD with strobe 4'b0101 to 32'h10004, then reads it -> write response and read both give 32'h11BB33DD.
- **Same-word conflicts:**
  - ch0 and ch1 both write 32'h10008 in one cycle, ch0=32'h000000FF strobe 4'b1111, ch1=32'h00000011 strobe 4'b0001 -> mem[2]=32'h00000011.
  - Separately, ch0 reads a word while ch1 writes it in the same cycle -> the read returns the old value.
- **Out-of-range access:** read 32'h0000FFFC and write to BASE_ADR+4*DEPTH -> resp=0, resp_err=1, memory unchanged.
- **Exit write:** ch1 writes 32'h2A to EXIT_ADR -> exit_v=1 and exit_code=32'h2A at the accept edge; both stay set through later traffic; rst_n low clears them.
- **Reset and stall injection:**
  - Accept 3 back-to-back reads with LATENCY=4, then assert rst_n after 2 cycles -> no resp_valid ever.
  - With SIM_MEM_STALL_INJECT_EN defined: a random back-to-back request stream on 2 channels is held by the requesters while ready=0 -> no lost or duplicated responses, and every response matches a reference model.

Source files
------------

// File: rtl/sim_mem_nport.sv
// Multi-channel simulation memory: NPORT request/response channels into one word array,
// pipelined response latency, byte strobes, range errors and a program-exit register.
// Optional ready stall injection is enabled by defining SIM_MEM_STALL_INJECT_EN.
module sim_mem_nport #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned NPORT      = 2,
  parameter logic [31:0] BASE_ADR   = 32'h10000,
  parameter int unsigned DEPTH      = 8192,
  parameter int unsigned LATENCY    = 1,
  parameter logic [31:0] EXIT_ADR   = 32'h0,
  parameter logic [15:0] STALL_SEED = 16'hACE1
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NPORT-1:0]                 r_v,
  input  logic [NPORT-1:0]                 w_v,
  input  logic [NPORT-1:0][XLEN-1:0]       adr,
  input  logic [NPORT-1:0][XLEN-1:0]       data,
  input  logic [NPORT-1:0][XLEN/8-1:0]     strobe,
  output logic [NPORT-1:0]                 ready,
  output logic [NPORT-1:0][XLEN-1:0]       resp,
  output logic [NPORT-1:0]                 resp_valid,
  output logic [NPORT-1:0]                 resp_err,
  output logic                             exit_v,
  output logic [XLEN-1:0]                  exit_code
);

  localparam int unsigned   SW      = XLEN / 8;
  localparam int unsigned   AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [XLEN-1:0] BASE  = XLEN'(BASE_ADR);
  localparam logic [XLEN-1:0] EXITA = XLEN'(EXIT_ADR);
  localparam logic [XLEN-1:0] DEPTHW = XLEN'(DEPTH);

  logic [XLEN-1:0] mem [DEPTH];

  logic [NPORT-1:0]                  w_acc, w_inr, w_exit;
  logic [NPORT-1:0][XLEN-1:0]        w_adr_a, w_word, w_new, w_rsp;
  logic [NPORT-1:0][AW-1:0]          w_idx;
  logic [NPORT-1:0]                  w_err;
  logic [NPORT-1:0][1:0]             w_unused_lsb;

  logic                              r_started;
  logic [NPORT-1:0][LATENCY-1:0]     r_pv, r_perr;
  logic [NPORT-1:0][LATENCY-1:0][XLEN-1:0] r_pd;
  logic [NPORT-1:0]                  r_resp_valid, r_resp_err;
  logic [NPORT-1:0][XLEN-1:0]        r_resp;
  logic                              r_exit_v;
  logic [XLEN-1:0]                   r_exit_code;

  // Address decode and accept per channel
  always_comb begin
    for (int c = 0; c < int'(NPORT); c++) begin
      w_unused_lsb[c] = adr[c][1:0];
      w_adr_a[c] = {adr[c][XLEN-1:2], 2'b00};
      w_word[c]  = (w_adr_a[c] - BASE) >> 2;
      w_inr[c]   = (w_adr_a[c] >= BASE) && (w_word[c] < DEPTHW);
      w_idx[c]   = w_word[c][AW-1:0];
      w_exit[c]  = w_v[c] && (w_adr_a[c] == EXITA);
      w_acc[c]   = (r_v[c] | w_v[c]) && ready[c];
    end
  end

  // Final word for each write target: all same-word writers merged, higher channel wins per byte
  always_comb begin
    for (int c = 0; c < int'(NPORT); c++) begin
      w_new[c] = mem[w_idx[c]];
      for (int j = 0; j < int'(NPORT); j++) begin
        if (w_acc[j] && w_v[j] && !w_exit[j] && w_inr[j] && (w_idx[j] == w_idx[c])) begin
          for (int b = 0; b < int'(SW); b++) begin
            if (strobe[j][b]) w_new[c][8*b +: 8] = data[j][8*b +: 8];
          end
        end
      end
    end
  end

  // Response payload; reads see the pre-edge memory contents
  always_comb begin
    for (int c = 0; c < int'(NPORT); c++) begin
      w_rsp[c] = '0;
      w_err[c] = 1'b1;
      if (w_exit[c]) begin
        w_rsp[c] = data[c];
        w_err[c] = 1'b0;
      end else if (w_v[c]) begin
        if (w_inr[c]) begin
          w_rsp[c] = w_new[c];
          w_err[c] = 1'b0;
        end
      end else if (w_inr[c] && (w_adr_a[c] != EXITA)) begin
        w_rsp[c] = mem[w_idx[c]];
        w_err[c] = 1'b0;
      end
    end
  end

  // Storage is never reset so preloaded contents survive a mid-run reset
  always_ff @(posedge clk) begin
    for (int c = 0; c < int'(NPORT); c++) begin
      if (w_acc[c] && w_v[c] && !w_exit[c] && w_inr[c]) mem[w_idx[c]] <= w_new[c];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_started    <= 1'b0;
      r_pv         <= '0;
      r_perr       <= '0;
      r_pd         <= '0;
      r_resp_valid <= '0;
      r_resp_err   <= '0;
      r_resp       <= '0;
      r_exit_v     <= 1'b0;
      r_exit_code  <= '0;
    end else begin
      r_started <= 1'b1;
      for (int c = 0; c < int'(NPORT); c++) begin
        r_pv[c][0]   <= w_acc[c];
        r_perr[c][0] <= w_err[c];
        r_pd[c][0]   <= w_rsp[c];
        for (int k = 1; k < int'(LATENCY); k++) begin
          r_pv[c][k]   <= r_pv[c][k-1];
          r_perr[c][k] <= r_perr[c][k-1];
          r_pd[c][k]   <= r_pd[c][k-1];
        end
        r_resp_valid[c] <= r_pv[c][LATENCY-1];
        if (r_pv[c][LATENCY-1]) begin
          r_resp[c]     <= r_pd[c][LATENCY-1];
          r_resp_err[c] <= r_perr[c][LATENCY-1];
        end
        // Ascending loop: the highest channel's exit data is the one that sticks
        if (w_acc[c] && w_exit[c]) begin
          r_exit_v    <= 1'b1;
          r_exit_code <= data[c];
        end
      end
    end
  end

`ifdef SIM_MEM_STALL_INJECT_EN
  logic [NPORT-1:0][15:0] r_lfsr;

  // Fibonacci LFSR x^16+x^14+x^13+x^11+1 per channel
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < int'(NPORT); c++) r_lfsr[c] <= STALL_SEED ^ 16'(c);
    end else begin
      for (int c = 0; c < int'(NPORT); c++) begin
        r_lfsr[c] <= {r_lfsr[c][14:0],
                      r_lfsr[c][15] ^ r_lfsr[c][13] ^ r_lfsr[c][12] ^ r_lfsr[c][10]};
      end
    end
  end

  always_comb begin
    for (int c = 0; c < int'(NPORT); c++) ready[c] = r_started && (r_lfsr[c][3:0] != 4'd0);
  end
`else
  assign ready = {NPORT{r_started}};
`endif

  assign resp_valid = r_resp_valid;
  assign resp       = r_resp;
  assign resp_err   = r_resp_err;
  assign exit_v     = r_exit_v;
  assign exit_code  = r_exit_code;

endmodule

// File: tb/tb_sim_mem_nport.sv
// Randomized self-checking bench for sim_mem_nport (2 channels, LATENCY=3) against a
// transaction-level memory model with per-channel expected-response queues.
module tb_sim_mem_nport;

  localparam int unsigned NP    = 2;
  localparam int unsigned LAT   = 3;
  localparam int unsigned DEPTH = 8192;
  localparam logic [31:0] BASE  = 32'h10000;
  localparam logic [31:0] EXITA = 32'h0;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [NP-1:0]           t_rv, t_wv;
  logic [NP-1:0][31:0]     t_adr, t_data;
  logic [NP-1:0][3:0]      t_strb;
  logic [NP-1:0]           ready, resp_valid, resp_err;
  logic [NP-1:0][31:0]     resp;
  logic                    exit_v;
  logic [31:0]             exit_code;

  sim_mem_nport #(
    .XLEN(32), .NPORT(NP), .BASE_ADR(BASE), .DEPTH(DEPTH),
    .LATENCY(LAT), .EXIT_ADR(EXITA), .STALL_SEED(16'hACE1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .r_v(t_rv), .w_v(t_wv), .adr(t_adr), .data(t_data),
    .strobe(t_strb), .ready(ready), .resp(resp), .resp_valid(resp_valid),
    .resp_err(resp_err), .exit_v(exit_v), .exit_code(exit_code)
  );

  typedef struct {
    int          due;
    logic        err;
    logic [31:0] d;
  } exp_t;

  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;
  exp_t        q[NP][$];
  logic [31:0] mm[16];
  logic        m_exit_v;
  logic [31:0] m_exit_code;

  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic in_range(input logic [31:0] a);
    return (a >= BASE) && (((a - BASE) >> 2) < DEPTH);
  endfunction

  // Model one accept edge: reads see old memory, writes land in channel order,
  // write responses carry the resulting stored word.
  task automatic model_accept(input logic [NP-1:0] acc);
    logic [31:0] a[NP];
    exp_t        e[NP];
    for (int c = 0; c < NP; c++) begin
      a[c] = {t_adr[c][31:2], 2'b00};
      e[c].due = cyc + 1 + LAT;
      e[c].err = 1'b1;
      e[c].d   = '0;
      if (acc[c] && !t_wv[c] && in_range(a[c]) && a[c] != EXITA) begin
        e[c].err = 1'b0;
        e[c].d   = mm[(a[c] - BASE) >> 2];
      end
    end
    for (int c = 0; c < NP; c++) begin
      if (acc[c] && t_wv[c]) begin
        if (a[c] == EXITA) begin
          m_exit_v    = 1'b1;
          m_exit_code = t_data[c];
        end else if (in_range(a[c])) begin
          for (int b = 0; b < 4; b++)
            if (t_strb[c][b]) mm[(a[c] - BASE) >> 2][8*b +: 8] = t_data[c][8*b +: 8];
        end
      end
    end
    for (int c = 0; c < NP; c++) begin
      if (acc[c] && t_wv[c]) begin
        if (a[c] == EXITA) begin
          e[c].err = 1'b0;
          e[c].d   = t_data[c];
        end else if (in_range(a[c])) begin
          e[c].err = 1'b0;
          e[c].d   = mm[(a[c] - BASE) >> 2];
        end
      end
      if (acc[c]) q[c].push_back(e[c]);
    end
  endtask

  // Response scoreboard: a pulse exactly when the oldest expected entry is due
  always @(negedge clk) begin
    for (int c = 0; c < NP; c++) begin
      if (q[c].size() != 0 && q[c][0].due == cyc) begin
        check($sformatf("ch%0d_valid", c), 64'(resp_valid[c]), 64'd1);
        check($sformatf("ch%0d_resp", c), 64'(resp[c]), 64'(q[c][0].d));
        check($sformatf("ch%0d_err", c), 64'(resp_err[c]), 64'(q[c][0].err));
        void'(q[c].pop_front());
      end else begin
        check($sformatf("ch%0d_valid", c), 64'(resp_valid[c]), 64'd0);
      end
    end
  end

  task automatic idle(input int n);
    t_rv = '0;
    t_wv = '0;
    repeat (n) @(negedge clk);
  endtask

  // Present a request set, holding each channel until it is accepted
  task automatic xfer(input logic [NP-1:0] rv, input logic [NP-1:0] wv,
                      input logic [NP-1:0][31:0] a, input logic [NP-1:0][31:0] d,
                      input logic [NP-1:0][3:0] s);
    logic [NP-1:0] pend;
    logic [NP-1:0] acc;
    int            guard;
    pend  = rv | wv;
    guard = 0;
    while (pend != '0 && guard < 64) begin
      t_rv   = rv & pend;
      t_wv   = wv & pend;
      t_adr  = a;
      t_data = d;
      t_strb = s;
      acc    = pend & ready;
      model_accept(acc);
      pend   = pend & ~acc;
      @(negedge clk);
      guard++;
    end
    t_rv = '0;
    t_wv = '0;
    if (pend != '0) check("xfer_timeout", 64'(pend), 64'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [NP-1:0]       p_pend, p_rv, p_wv, acc;
    logic [NP-1:0][31:0] p_adr, p_d;
    logic [NP-1:0][3:0]  p_s;
    int                  r;

    t_rv = '0; t_wv = '0; t_adr = '0; t_data = '0; t_strb = '0;
    for (int i = 0; i < 16; i++) mm[i] = $urandom;
    mm[0] = 32'hDEADBEEF;
    mm[1] = 32'h11223344;
    mm[2] = 32'h0;
    for (int i = 0; i < 16; i++) dut.mem[i] = mm[i];
    m_exit_v = 1'b0;
    m_exit_code = '0;

    repeat (3) @(negedge clk);
    check("rst_ready", 64'(ready), 64'd0);
    check("rst_resp", 64'(resp), 64'd0);
    check("rst_err", 64'(resp_err), 64'd0);
    check("rst_exit_v", 64'(exit_v), 64'd0);
    check("rst_exit_code", 64'(exit_code), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
`ifndef SIM_MEM_STALL_INJECT_EN
    check("ready_after_rst", 64'(ready), 64'h3);
`endif

    // Read latency
    xfer(2'b01, 2'b00, {32'h0, 32'h10000}, '0, '0);
    idle(LAT + 2);

    // Strobed write then readback on ch1
    xfer(2'b00, 2'b10, {32'h10004, 32'h0}, {32'hAABBCCDD, 32'h0}, {4'b0101, 4'b0000});
    xfer(2'b10, 2'b00, {32'h10004, 32'h0}, '0, '0);
    idle(LAT + 2);
    check("strobe_mem", 64'(dut.mem[1]), 64'h11BB33DD);

    // Same-word write conflict, then read/write conflict
    xfer(2'b00, 2'b11, {32'h10008, 32'h10008}, {32'h00000011, 32'h000000FF},
         {4'b0001, 4'b1111});
    idle(LAT + 2);
    check("conflict_mem", 64'(dut.mem[2]), 64'(mm[2]));
    xfer(2'b01, 2'b10, {32'h10000, 32'h10000}, {32'h12345678, 32'h0}, {4'b1111, 4'b0000});
    idle(LAT + 2);

    // Out-of-range read and write
    xfer(2'b01, 2'b00, {32'h0, 32'h0000FFFC}, '0, '0);
    xfer(2'b00, 2'b01, {32'h0, BASE + 32'(4 * DEPTH)}, {32'h0, 32'hCAFEF00D}, {4'b0, 4'hF});
    xfer(2'b01, 2'b00, {32'h0, EXITA}, '0, '0);
    idle(LAT + 2);

    // Exit write: flag visible right after the accept edge, strobe ignored
    xfer(2'b00, 2'b10, {EXITA, 32'h0}, {32'h2A, 32'h0}, {4'b0000, 4'b0000});
    check("exit_v_set", 64'(exit_v), 64'd1);
    check("exit_code_set", 64'(exit_code), 64'h2A);
    xfer(2'b11, 2'b00, {32'h1000C, 32'h10010}, '0, '0);
    idle(LAT + 2);
    check("exit_v_sticky", 64'(exit_v), 64'd1);
    check("exit_code_sticky", 64'(exit_code), 64'h2A);

    // Reset with three reads in flight
    xfer(2'b01, 2'b00, {32'h0, 32'h10000}, '0, '0);
    xfer(2'b01, 2'b00, {32'h0, 32'h10004}, '0, '0);
    xfer(2'b01, 2'b00, {32'h0, 32'h10008}, '0, '0);
    rst_n = 1'b0;
    for (int c = 0; c < NP; c++) q[c].delete();
    m_exit_v = 1'b0;
    m_exit_code = '0;
    repeat (2) @(negedge clk);
    check("rst_mid_exit_v", 64'(exit_v), 64'd0);
    check("rst_mid_exit_code", 64'(exit_code), 64'd0);
    rst_n = 1'b1;
    idle(LAT + 4);
    check("mem_preserved", 64'(dut.mem[0]), 64'(mm[0]));

    // Random two-channel stream, requests held while not ready
    p_pend = '0; p_rv = '0; p_wv = '0; p_adr = '0; p_d = '0; p_s = '0;
    for (int n = 0; n < 400; n++) begin
      for (int c = 0; c < NP; c++) begin
        if (!p_pend[c] && $urandom_range(0, 9) < 8) begin
          p_pend[c] = 1'b1;
          r = $urandom_range(0, 2);
          p_rv[c] = (r != 1);
          p_wv[c] = (r != 0);
          r = $urandom_range(0, 19);
          if (r < 16)       p_adr[c] = BASE + 32'(4 * r) + 32'($urandom_range(0, 3));
          else if (r == 16) p_adr[c] = 32'h0000FFFC;
          else if (r == 17) p_adr[c] = BASE + 32'(4 * DEPTH);
          else              p_adr[c] = EXITA;
          p_d[c] = $urandom;
          p_s[c] = 4'($urandom_range(0, 15));
        end
      end
      t_rv   = p_rv & p_pend;
      t_wv   = p_wv & p_pend;
      t_adr  = p_adr;
      t_data = p_d;
      t_strb = p_s;
      acc    = p_pend & ready;
      model_accept(acc);
      p_pend = p_pend & ~acc;
      @(negedge clk);
    end
    idle(LAT + 4);
    check("drain", 64'(q[0].size() + q[1].size()), 64'd0);
    check("final_exit_v", 64'(exit_v), 64'(m_exit_v));
    check("final_exit_code", 64'(exit_code), 64'(m_exit_code));
    for (int i = 0; i < 16; i++) check($sformatf("final_mem%0d", i), 64'(dut.mem[i]), 64'(mm[i]));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
